// File: rtl/sdram_bram_responder.sv
// Block-RAM stand-in for the SDRAM driver front end. It accepts write bursts and
// read bursts, arbitrates between them round-robin and streams read data back.
module sdram_bram_responder #(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned MEM_DEPTH  = 4096,
  parameter int unsigned RD_LATENCY = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  writer_valid_i,
  output logic                  writer_ready_o,
  input  logic [ADDR_WIDTH-1:0] writer_addr_i,
  input  logic [DATA_WIDTH-1:0] writer_data_i,
  input  logic                  reader_valid_i,
  output logic                  reader_ready_o,
  input  logic [ADDR_WIDTH-1:0] reader_addr_i,
  output logic                  resp_valid_o,
  output logic                  resp_last_o,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  input  logic                  resp_ready_i,
  output logic                  busy_o,
  output logic                  wr_done_o,
  output logic                  rd_done_o
);

  localparam int unsigned MAW = $clog2(MEM_DEPTH);
  localparam int unsigned CW  = $clog2(BURST_LEN);
  localparam int unsigned LW  = $clog2(RD_LATENCY);
  localparam logic [CW-1:0] LAST_IDX = CW'(BURST_LEN - 1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(RD_LATENCY - 2);

  typedef enum logic [1:0] {IDLE, WR_DATA, RD_WAIT, RD_DATA} state_e;
  typedef enum logic {GRANT_READ, GRANT_WRITE} grant_e;

  state_e                state_q, state_d;
  grant_e                grant_q, grant_d;
  logic [MAW-1:0]        addr_q, addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         ptr_q, ptr_d;
  logic [LW-1:0]         lat_q, lat_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_last_q, resp_last_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  wr_done_q, wr_done_d;
  logic                  rd_done_q, rd_done_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] ram_rd_q;
  logic [MAW-1:0]        ram_addr;
  logic [MAW-1:0]        wr_addr;
  logic                  ram_en;
  logic                  mem_we;
  logic                  wr_rdy, rd_rdy;
  logic                  wr_hs, rd_hs, resp_hs;
  logic                  unused_addr;

  assign unused_addr = ^{writer_addr_i, reader_addr_i};
  assign wr_addr     = addr_q + MAW'(cnt_q);

  always_comb begin
    wr_rdy = 1'b0;
    rd_rdy = 1'b0;
    case (state_q)
      IDLE: begin
        wr_rdy = !(reader_valid_i && grant_q == GRANT_WRITE);
        rd_rdy = !(writer_valid_i && grant_q == GRANT_READ);
      end
      WR_DATA: wr_rdy = 1'b1;
      default: ;
    endcase
    if (rst_i) begin
      wr_rdy = 1'b0;
      rd_rdy = 1'b0;
    end
  end

  assign wr_hs   = writer_valid_i && wr_rdy;
  assign rd_hs   = reader_valid_i && rd_rdy;
  assign resp_hs = resp_valid_q && resp_ready_i;

  // ram_rd_q always holds the word after the one presented, so a response
  // handshake can advance the output without a bubble.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    ptr_d        = ptr_q;
    lat_d        = lat_q;
    resp_valid_d = resp_valid_q;
    resp_last_d  = resp_last_q;
    resp_data_d  = resp_data_q;
    wr_done_d    = 1'b0;
    rd_done_d    = 1'b0;
    mem_we       = 1'b0;
    ram_en       = 1'b0;
    ram_addr     = addr_q + MAW'(ptr_q);
    case (state_q)
      IDLE: begin
        if (wr_hs) begin
          addr_d  = writer_addr_i[MAW-1:0];
          cnt_d   = '0;
          grant_d = GRANT_WRITE;
          state_d = WR_DATA;
        end else if (rd_hs) begin
          addr_d   = reader_addr_i[MAW-1:0];
          lat_d    = LAT_LOAD;
          grant_d  = GRANT_READ;
          state_d  = RD_WAIT;
          ram_en   = 1'b1;
          ram_addr = reader_addr_i[MAW-1:0];
          ptr_d    = CW'(1);
        end
      end
      WR_DATA: begin
        if (wr_hs) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST_IDX) begin
            state_d   = IDLE;
            wr_done_d = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        if (lat_q == '0) begin
          state_d      = RD_DATA;
          resp_valid_d = 1'b1;
          resp_last_d  = 1'b0;
          resp_data_d  = ram_rd_q;
          idx_d        = '0;
          ram_en       = 1'b1;
          ptr_d        = ptr_q + CW'(1);
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      RD_DATA: begin
        if (resp_hs) begin
          if (idx_q == LAST_IDX) begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
            resp_last_d  = 1'b0;
            rd_done_d    = 1'b1;
          end else begin
            idx_d       = idx_q + CW'(1);
            resp_data_d = ram_rd_q;
            resp_last_d = (idx_q + CW'(1)) == LAST_IDX;
            ram_en      = 1'b1;
            ptr_d       = ptr_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_READ;
      addr_q       <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      ptr_q        <= '0;
      lat_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_data_q  <= '0;
      wr_done_q    <= 1'b0;
      rd_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      ptr_q        <= ptr_d;
      lat_q        <= lat_d;
      resp_valid_q <= resp_valid_d;
      resp_last_q  <= resp_last_d;
      resp_data_q  <= resp_data_d;
      wr_done_q    <= wr_done_d;
      rd_done_q    <= rd_done_d;
    end
  end

  // Backing store is never reset; a burst abandoned by reset keeps its words.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[wr_addr] <= writer_data_i;
    if (ram_en) ram_rd_q <= mem[ram_addr];
  end

  assign writer_ready_o = wr_rdy;
  assign reader_ready_o = rd_rdy;
  assign resp_valid_o   = resp_valid_q && !rst_i;
  assign resp_last_o    = resp_last_q && !rst_i;
  assign resp_data_o    = resp_data_q;
  assign busy_o         = (state_q != IDLE) && !rst_i;
  assign wr_done_o      = wr_done_q && !rst_i;
  assign rd_done_o      = rd_done_q && !rst_i;

endmodule

// File: tb/tb_sdram_bram_responder.sv
// Directed bench for sdram_bram_responder: a per-cycle vector table for the basic
// write/read burst, then hand-written sequences for stalls, arbitration, wrap and reset.
module tb_sdram_bram_responder;

  localparam int unsigned RD_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wv, rv, rr;
  logic [23:0] wa, ra;
  logic [15:0] wd;
  logic        wready, rready, rvalid, rlast, busy, wdone, rdone;
  logic [15:0] rdata;

  int checks = 0;
  int failures = 0;
  logic [15:0] rd_beats [8];
  int rd_n;

  typedef struct {
    logic        wv;
    logic [23:0] wa;
    logic [15:0] wd;
    logic        rv;
    logic [23:0] ra;
    logic        rr;
    logic        e_wready, e_rready, e_rvalid, e_rlast;
    logic [15:0] e_rdata;
    logic        e_busy, e_wdone, e_rdone;
  } vec_t;

  vec_t vt[$];

  sdram_bram_responder #(
    .ADDR_WIDTH(24),
    .DATA_WIDTH(16),
    .BURST_LEN (8),
    .MEM_DEPTH (4096),
    .RD_LATENCY(RD_LAT)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .writer_valid_i(wv),
    .writer_ready_o(wready),
    .writer_addr_i (wa),
    .writer_data_i (wd),
    .reader_valid_i(rv),
    .reader_ready_o(rready),
    .reader_addr_i (ra),
    .resp_valid_o  (rvalid),
    .resp_last_o   (rlast),
    .resp_data_o   (rdata),
    .resp_ready_i  (rr),
    .busy_o        (busy),
    .wr_done_o     (wdone),
    .rd_done_o     (rdone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v_wv, input logic [23:0] v_wa, input logic [15:0] v_wd,
                              input logic v_rv, input logic [23:0] v_ra, input logic v_rr,
                              input logic x_wr, input logic x_rr, input logic x_rv, input logic x_rl,
                              input logic [15:0] x_rd, input logic x_busy, input logic x_wd,
                              input logic x_rdn);
    vec_t v;
    v.wv = v_wv; v.wa = v_wa; v.wd = v_wd; v.rv = v_rv; v.ra = v_ra; v.rr = v_rr;
    v.e_wready = x_wr; v.e_rready = x_rr; v.e_rvalid = x_rv; v.e_rlast = x_rl;
    v.e_rdata = x_rd; v.e_busy = x_busy; v.e_wdone = x_wd; v.e_rdone = x_rdn;
    return v;
  endfunction

  task automatic write_burst(input logic [23:0] addr, input logic [15:0] d0,
                             input int gap_after, input int gap_len);
    int sent, gapc, guard;
    sent = 0; gapc = 0; guard = 0;
    while (sent < 9 && guard < 100) begin
      if (sent >= 1 && sent - 1 == gap_after && gapc < gap_len) begin
        wv = 1'b0; wd = 16'hDEAD; wa = 24'hFFFFFF; gapc++;
        #1;
        chk("gap busy", busy, 1);
        chk("gap no wr_done", wdone, 0);
      end else begin
        wv = 1'b1; wa = addr;
        wd = (sent == 0) ? 16'h5A5A : d0 + 16'(sent - 1);
        #1;
        if (wready) sent++;
      end
      tick();
      guard++;
    end
    wv = 1'b0;
    chk("wr beats accepted", sent, 9);
    chk("wr_done pulse", wdone, 1);
    chk("busy after wr", busy, 0);
    tick();
    chk("wr_done one cycle", wdone, 0);
  endtask

  task automatic read_burst(input logic [23:0] addr, input bit stall);
    int c, guard, first_c;
    bit seen_done, pv_stall;
    logic [15:0] pd;
    logic pl;
    rd_n = 0; first_c = -1; seen_done = 0; pv_stall = 0; guard = 0;
    pd = '0; pl = 1'b0;
    rv = 1'b1; ra = addr; rr = 1'b1;
    #1;
    while (!rready && guard < 50) begin
      tick();
      guard++;
      #1;
    end
    chk("rd accept", rready, 1);
    tick();
    rv = 1'b0;
    c = 1;
    while (!seen_done && c < 100) begin
      rr = stall ? (c % 3 == 1) : 1'b1;
      #1;
      if (rvalid) begin
        if (first_c < 0) first_c = c;
        if (pv_stall) begin
          chk("stall data stable", rdata, pd);
          chk("stall last stable", rlast, pl);
        end
        if (rr) begin
          if (rd_n < 8) begin
            rd_beats[rd_n] = rdata;
            chk($sformatf("beat%0d last", rd_n), rlast, rd_n == 7);
          end
          rd_n++;
        end
        pv_stall = !rr; pd = rdata; pl = rlast;
      end else begin
        pv_stall = 0;
      end
      if (rdone) seen_done = 1;
      tick();
      c++;
    end
    chk("rd latency", first_c, RD_LAT);
    chk("rd beat count", rd_n, 8);
    chk("rd_done seen", seen_done, 1);
    chk("rd_done one cycle", rdone, 0);
    rr = 1'b1;
  endtask

  initial begin
    int g[$];
    int wbeat, ndone, guard, rn;
    bit both;

    rst = 1'b1; wv = 0; rv = 0; rr = 1; wa = '0; ra = '0; wd = '0;
    tick(); tick();
    chk("reset wready", wready, 0);
    chk("reset rready", rready, 0);
    chk("reset rvalid", rvalid, 0);
    chk("reset rlast", rlast, 0);
    chk("reset rdata", rdata, 0);
    chk("reset busy", busy, 0);
    chk("reset done", {wdone, rdone}, 0);
    tick();
    rst = 1'b0;

    // Basic write then read burst at 0x10, one vector per cycle.
    vt.push_back(mk(1, 24'h10, 16'h5555, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      vt.push_back(mk(1, 24'h10, 16'h1000 + 16'(i), 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 24'h10, 1, 0, 1, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      vt.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 8; i++)
      vt.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, i == 7, 16'h1000 + 16'(i), 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));

    foreach (vt[i]) begin
      wv = vt[i].wv; wa = vt[i].wa; wd = vt[i].wd;
      rv = vt[i].rv; ra = vt[i].ra; rr = vt[i].rr;
      #1;
      chk($sformatf("v%0d wready", i), wready, vt[i].e_wready);
      chk($sformatf("v%0d rready", i), rready, vt[i].e_rready);
      chk($sformatf("v%0d rvalid", i), rvalid, vt[i].e_rvalid);
      chk($sformatf("v%0d rlast", i), rlast, vt[i].e_rlast);
      if (vt[i].e_rvalid) chk($sformatf("v%0d rdata", i), rdata, vt[i].e_rdata);
      chk($sformatf("v%0d busy", i), busy, vt[i].e_busy);
      chk($sformatf("v%0d wr_done", i), wdone, vt[i].e_wdone);
      chk($sformatf("v%0d rd_done", i), rdone, vt[i].e_rdone);
      tick();
    end

    // Same read with resp_ready toggling 1,0,0.
    read_burst(24'h10, 1);
    for (int i = 0; i < 8; i++) chk($sformatf("stall rd beat%0d", i), rd_beats[i], 16'h1000 + 16'(i));

    // Both ports valid from reset: grants must go W, R, W.
    rst = 1'b1; wv = 0; rv = 0;
    tick(); tick();
    rst = 1'b0;
    wa = 24'h40; ra = 24'h40; rr = 1'b1;
    wbeat = 0; ndone = 0; guard = 0; rn = 0; both = 0;
    while (ndone < 2 && guard < 300) begin
      wv = (wbeat < 16);
      rv = (g.size() < 3);
      wd = 16'h2100 + 16'(wbeat);
      #1;
      if (wv && rv && wready && rready) both = 1;
      if (!busy) begin
        if (wv && wready) g.push_back(1);
        if (rv && rready) g.push_back(2);
      end else if (wv && wready) begin
        wbeat++;
      end
      if (rvalid && rr && rn < 8) begin
        rd_beats[rn] = rdata;
        rn++;
      end
      if (wdone) ndone++;
      tick();
      guard++;
    end
    wv = 0; rv = 0;
    chk("arb wr_done count", ndone, 2);
    chk("arb readies exclusive", both, 0);
    chk("arb grant count", g.size(), 3);
    if (g.size() >= 3) begin
      chk("arb grant0 write", g[0], 1);
      chk("arb grant1 read", g[1], 2);
      chk("arb grant2 write", g[2], 1);
    end
    chk("arb rd beats", rn, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("arb rd beat%0d", i), rd_beats[i], 16'h2100 + 16'(i));

    // Burst crossing the top of memory wraps to word 0; upper address bits alias.
    write_burst(24'h000FFC, 16'h00A0, -1, 0);
    read_burst(24'h000000, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap low beat%0d", i), rd_beats[i], 16'h00A4 + 16'(i));
    read_burst(24'h000FFC, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("wrap full beat%0d", i), rd_beats[i], 16'h00A0 + 16'(i));
    read_burst(24'h801000, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("alias beat%0d", i), rd_beats[i], 16'h00A4 + 16'(i));

    // Reset after three data beats of a burst.
    wv = 1'b1; wa = 24'h100;
    for (int i = 0; i < 4; i++) begin
      wd = (i == 0) ? 16'h0 : 16'h00B0 + 16'(i - 1);
      tick();
    end
    wv = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst wready", wready, 0);
    chk("midrst rready", rready, 0);
    chk("midrst busy", busy, 0);
    chk("midrst rvalid", rvalid, 0);
    chk("midrst rlast", rlast, 0);
    chk("midrst done", {wdone, rdone}, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("postrst busy", busy, 0);
    chk("postrst rdata", rdata, 0);
    chk("postrst wready", wready, 1);
    write_burst(24'h200, 16'h00C0, -1, 0);
    read_burst(24'h100, 0);
    for (int i = 0; i < 3; i++) chk($sformatf("partial beat%0d", i), rd_beats[i], 16'h00B0 + 16'(i));
    read_burst(24'h200, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("postrst burst beat%0d", i), rd_beats[i], 16'h00C0 + 16'(i));

    // Write burst with a 5-cycle gap after the third data beat.
    write_burst(24'h300, 16'h00D0, 3, 5);
    read_burst(24'h300, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("gap beat%0d", i), rd_beats[i], 16'h00D0 + 16'(i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
